gps_ca_code_gen: RTL and testbench
==================================

GPS_CA_CODE_GEN -- requirements
Module: gps_ca_code_gen

Interface
REQ-001 SHALL have port clkin, input, 1 bit: the single system clock (20 MHz); all logic is clocked on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port clk_ca_1023, input, 1 bit: 1.023 MHz code clock from the NCO stage, synchronous to clkin; used as data only, never as a clock.
REQ-004 SHALL have port prn_sel, input, 6 bits: satellite PRN number; 1..32 valid.
REQ-005 SHALL have port load, input, 1 bit: one-cycle pulse that latches prn_sel and restarts the code.
REQ-006 SHALL have port ca_chip, output, 1 bit: current C/A chip value (registered).
REQ-007 SHALL have port chip_valid, output, 1 bit: one-cycle pulse each time ca_chip advances.
REQ-008 SHALL have port epoch, output, 1 bit: one-cycle pulse when chip 0 of a code period is presented.
REQ-009 SHALL have port chip_cnt, output, 10 bits: index of the current chip, 0..1022.
REQ-010 SHALL have port active, output, 1 bit: high while in RUN.

Function
REQ-011 SHALL register clk_ca_1023 into clk_d1 and form chip_en = clk_ca_1023 & ~clk_d1 (rising-edge detect, one clkin cycle wide).
REQ-012 SHALL implement FSM states IDLE and RUN; IDLE->RUN on load with prn_sel in 1..32; RUN->IDLE on load with an invalid prn_sel (0 or 33..63); IDLE otherwise holds.
REQ-013 On an accepted load, SHALL in the same edge latch the PRN, set G1 and G2 to all ones, set chip_cnt=0, set ca_chip=1 (chip 0 value for all-ones state), and pulse epoch; chip_valid stays low.
REQ-014 SHALL compute G1 as a 10-stage LFSR with feedback G1[3]^G1[10] and G2 as a 10-stage LFSR with feedback G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10], stages numbered 1..10 with shift toward stage 10.
REQ-015 SHALL compute the chip as G1[10] ^ G2[a] ^ G2[b], where (a,b) is the G2 phase-selector pair for the latched PRN per IS-GPS-200 Table 3-Ia (PRN1=(2,6), PRN2=(3,7), ...).
REQ-016 In RUN, on each chip_en, SHALL shift both LFSRs, register the new chip into ca_chip, increment chip_cnt, and pulse chip_valid in the following cycle (latency: 1 clkin from chip_en).
REQ-017 SHALL wrap chip_cnt from 1022 to 0, force G1 and G2 to all ones on that wrap, and pulse epoch together with chip_valid.
REQ-018 When load and chip_en coincide, SHALL let load win and discard chip_en for that cycle.
REQ-019 SHALL ignore changes on prn_sel except at an accepted load.
REQ-020 In IDLE, SHALL hold ca_chip=0, chip_cnt=0, chip_valid=0, epoch=0, and active=0, and SHALL ignore chip_en.

Reset
REQ-021 On rst=1 at a clkin edge, SHALL enter IDLE with ca_chip=0, chip_valid=0, epoch=0, chip_cnt=0, active=0, clk_d1=0, G1/G2 all ones, and latched PRN=0.
REQ-022 Reset asserted mid-run SHALL override load and chip_en; after release, the block SHALL remain in IDLE until the next valid load.

Structure
REQ-023 SHALL place the 32-entry G2 phase-selector table, the G1/G2 tap constants, CODE_LEN=1023, and the FSM state encoding in shared package gps_ca_pkg.
REQ-024 SHALL implement the PRN-to-tap lookup and chip XOR as one combinational sub-module gps_ca_g2_sel; the LFSRs, FSM and counter stay in the top module.

Verification
REQ-025 Scenario: load with prn_sel=1, then drive 10 chip_en events -> ca_chip sequence 1,1,0,0,1,0,0,0,0,0 (octal 1440), with chip_cnt reaching 9.
REQ-026 Scenario: load with prn_sel=2, then drive 10 chips -> ca_chip sequence 1110010000 (octal 1620); over 1023 chips the count of ones is 512.
REQ-027 Scenario: drive clk_ca_1023 from the NCO at 20 MHz for 2 code periods -> epoch pulses exactly 1023 chip_valid pulses apart, and the second period is bit-identical to the first.
REQ-028 Scenario: prn_sel=0 or 40 with load -> active=0, ca_chip=0, and no chip_valid pulses; a subsequent load with prn_sel=5 -> active=1 and an epoch pulse.
REQ-029 Scenario: load coincident with chip_en at chip_cnt=500 -> chip_cnt=0, ca_chip=1, epoch=1, and chip_valid=0 in the following cycle.
REQ-030 Scenario: rst=1 for one cycle at chip_cnt=700 -> all outputs return to 0 on the next cycle, and the block stays in IDLE despite continuing chip_en.

Source files
------------

// File: rtl/gps_ca_pkg.sv
// GPS C/A code generator shared definitions:
// G1/G2 taps, PRN phase-selector table, FSM encoding.
package gps_ca_pkg;

  localparam int CODE_LEN = 1023;

  // Bit k of a [10:1] vector is LFSR stage k
  localparam logic [10:1] G1_TAPS = 10'b10_0000_0100;
  localparam logic [10:1] G2_TAPS = 10'b11_1010_0110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } g2_pair_t;

  // G2 phase-select stage pairs, index = PRN-1
  localparam logic [7:0] G2_SEL [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59,
    8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56,
    8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47,
    8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A,
    8'h16, 8'h27, 8'h38, 8'h49
  };

  function automatic logic [10:1] lfsr_step(
    input logic [10:1] s,
    input logic [10:1] taps
  );
    return {s[9:1], ^(s & taps)};
  endfunction

endpackage

// File: rtl/gps_ca_code_gen_if.sv
// Chip-stream bundle of the C/A code generator:
// code clock, PRN load request and chip outputs.
interface gps_ca_code_gen_if;
  logic       clk_ca_1023;
  logic [5:0] prn_sel;
  logic       load;
  logic       ca_chip;
  logic       chip_valid;
  logic       epoch;
  logic [9:0] chip_cnt;
  logic       active;

  modport master (
    output clk_ca_1023, prn_sel, load,
    input  ca_chip, chip_valid, epoch,
    input  chip_cnt, active
  );

  modport slave (
    input  clk_ca_1023, prn_sel, load,
    output ca_chip, chip_valid, epoch,
    output chip_cnt, active
  );
endinterface

// File: rtl/gps_ca_g2_sel.sv
// PRN phase-selector lookup and C/A chip XOR
// for a given G1/G2 register state.
module gps_ca_g2_sel
  import gps_ca_pkg::*;
(
  input  logic [5:0]  prn_i,
  input  logic [10:1] g1_i,
  input  logic [10:1] g2_i,
  output logic        chip_o
);

  logic [4:0] idx;
  g2_pair_t   pair;

  always_comb begin
    idx    = 5'(prn_i - 6'd1);
    pair   = G2_SEL[idx];
    chip_o = g1_i[10] ^ g2_i[pair.a] ^ g2_i[pair.b];
  end

endmodule

// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A Gold-code generator: IDLE/RUN FSM,
// G1/G2 LFSRs and chip counter advanced on code-clock edges.
module gps_ca_code_gen
  import gps_ca_pkg::*;
(
  input  logic       clkin,
  input  logic       rst,
  input  logic       clk_ca_1023,
  input  logic [5:0] prn_sel,
  input  logic       load,
  output logic       ca_chip,
  output logic       chip_valid,
  output logic       epoch,
  output logic [9:0] chip_cnt,
  output logic       active
);

  state_e      state_q, state_d;
  logic        clk_d1_q;
  logic [5:0]  prn_q, prn_d;
  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        chip_q, chip_d;
  logic        valid_q, valid_d;
  logic        epoch_q, epoch_d;

  logic        chip_en;
  logic        prn_ok;
  logic        wrap;
  logic [10:1] g1_adv;
  logic [10:1] g2_adv;
  logic        adv_chip;

  // Chip value of the state the LFSRs move to next
  gps_ca_g2_sel u_sel (
    .prn_i  (prn_q),
    .g1_i   (g1_adv),
    .g2_i   (g2_adv),
    .chip_o (adv_chip)
  );

  always_comb begin
    chip_en = clk_ca_1023 & ~clk_d1_q;
    prn_ok  = (prn_sel != 6'd0) && (prn_sel <= 6'd32);
    wrap    = (cnt_q == 10'(CODE_LEN - 1));
    g1_adv  = wrap ? '1 : lfsr_step(g1_q, G1_TAPS);
    g2_adv  = wrap ? '1 : lfsr_step(g2_q, G2_TAPS);

    state_d = state_q;
    prn_d   = prn_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    cnt_d   = cnt_q;
    chip_d  = chip_q;
    valid_d = 1'b0;
    epoch_d = 1'b0;

    unique case (1'b1)
      load && prn_ok: begin
        state_d = S_RUN;
        prn_d   = prn_sel;
        g1_d    = '1;
        g2_d    = '1;
        cnt_d   = '0;
        chip_d  = 1'b1;
        epoch_d = 1'b1;
      end
      load && !prn_ok: begin
        state_d = S_IDLE;
        g1_d    = '1;
        g2_d    = '1;
        cnt_d   = '0;
        chip_d  = 1'b0;
      end
      !load && (state_q == S_RUN) && chip_en: begin
        g1_d    = g1_adv;
        g2_d    = g2_adv;
        cnt_d   = wrap ? '0 : cnt_q + 10'd1;
        chip_d  = adv_chip;
        valid_d = 1'b1;
        epoch_d = wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q  <= S_IDLE;
      clk_d1_q <= 1'b0;
      prn_q    <= '0;
      g1_q     <= '1;
      g2_q     <= '1;
      cnt_q    <= '0;
      chip_q   <= 1'b0;
      valid_q  <= 1'b0;
      epoch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_d1_q <= clk_ca_1023;
      prn_q    <= prn_d;
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      cnt_q    <= cnt_d;
      chip_q   <= chip_d;
      valid_q  <= valid_d;
      epoch_q  <= epoch_d;
    end
  end

  assign ca_chip    = chip_q;
  assign chip_valid = valid_q;
  assign epoch      = epoch_q;
  assign chip_cnt   = cnt_q;
  assign active     = (state_q == S_RUN);

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Scoreboard bench for gps_ca_code_gen against a
// sequence-recurrence model of the GPS Gold codes.
module tb_gps_ca_code_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  gps_ca_code_gen_if bus();

  gps_ca_code_gen dut (
    .clkin       (clk),
    .rst         (rst),
    .clk_ca_1023 (bus.clk_ca_1023),
    .prn_sel     (bus.prn_sel),
    .load        (bus.load),
    .ca_chip     (bus.ca_chip),
    .chip_valid  (bus.chip_valid),
    .epoch       (bus.epoch),
    .chip_cnt    (bus.chip_cnt),
    .active      (bus.active)
  );

  typedef struct {
    bit chip;
    int cnt;
    bit ep;
    bit vld;
  } exp_t;

  exp_t sbq[$];
  bit   seen[$];
  int   epochs[$];
  int   vcount = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference code: code[p][i] for PRN p, chip i
  bit code [33][1023];
  int sel_a [33] = '{0,2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,
                     1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int sel_b [33] = '{0,6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,
                     4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  // Model state
  bit run    = 1'b0;
  bit prevca = 1'b0;
  int idx    = 0;
  int lprn   = 0;

  function automatic void chk(string n, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endfunction

  // Stage-10 output streams: s[t+10] from the feedback taps
  function automatic void build();
    bit g1s [1033];
    bit g2s [1033];
    for (int t = 0; t < 10; t++) begin
      g1s[t] = 1'b1;
      g2s[t] = 1'b1;
    end
    for (int t = 0; t < 1023; t++) begin
      g1s[t+10] = g1s[t+7] ^ g1s[t];
      g2s[t+10] = g2s[t+8] ^ g2s[t+7] ^ g2s[t+4]
                ^ g2s[t+2] ^ g2s[t+1] ^ g2s[t];
    end
    for (int p = 1; p <= 32; p++)
      for (int i = 0; i < 1023; i++)
        code[p][i] = g1s[i] ^ g2s[i+10-sel_a[p]]
                   ^ g2s[i+10-sel_b[p]];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.chip_valid || bus.epoch) begin
      if (bus.chip_valid) vcount++;
      if (bus.epoch) epochs.push_back(vcount);
      seen.push_back(bus.ca_chip);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got output cnt=%0d expected none",
                 bus.chip_cnt);
      end else begin
        e = sbq.pop_front();
        chk("sb_chip", bus.ca_chip, e.chip);
        chk("sb_cnt", bus.chip_cnt, e.cnt);
        chk("sb_flags", {bus.chip_valid, bus.epoch}, {e.vld, e.ep});
      end
    end
  end

  task automatic step(bit ca, bit ld, int p, bit r);
    bit en;
    bus.clk_ca_1023 = ca;
    bus.load        = ld;
    bus.prn_sel     = ld ? 6'(p) : 6'($urandom_range(0, 63));
    rst             = r;
    if (r) begin
      run    = 1'b0;
      prevca = 1'b0;
    end else begin
      en     = ca && !prevca;
      prevca = ca;
      if (ld) begin
        if (p >= 1 && p <= 32) begin
          run  = 1'b1;
          lprn = p;
          idx  = 0;
          sbq.push_back('{code[p][0], 0, 1'b1, 1'b0});
        end else begin
          run = 1'b0;
        end
      end else if (run && en) begin
        idx = (idx + 1) % 1023;
        sbq.push_back('{code[lprn][idx], idx, idx == 0, 1'b1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chips(int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 0, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic do_load(int p);
    step(1'b0, 1'b0, 0, 1'b0);
    seen.delete();
    epochs.delete();
    step(1'b0, 1'b1, p, 1'b0);
  endtask

  initial begin
    logic [9:0] v;
    int ones, v0, mism, p;
    logic [31:0] acc;
    build();

    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("reset_outs", {bus.ca_chip, bus.chip_valid, bus.epoch,
                       bus.chip_cnt, bus.active}, 0);

    do_load(1);
    chips(9);
    chk("prn1_cnt9", bus.chip_cnt, 9);
    step(1'b0, 1'b0, 0, 1'b0);
    v = '0;
    for (int k = 0; k < 10; k++) v = {v[8:0], seen[k]};
    chk("prn1_first10", v, 10'o1440);

    do_load(2);
    chips(1022);
    step(1'b0, 1'b0, 0, 1'b0);
    v = '0;
    for (int k = 0; k < 10; k++) v = {v[8:0], seen[k]};
    chk("prn2_first10", v, 10'o1620);
    ones = 0;
    for (int k = 0; k < 1023; k++) ones += int'(seen[k]);
    chk("prn2_ones", ones, 512);
    chips(3);

    repeat (6) begin
      do_load(int'($urandom_range(1, 32)));
      chips(int'($urandom_range(20, 80)));
    end

    do_load(0);
    chk("bad0_active", bus.active, 0);
    chk("bad0_chip", bus.ca_chip, 0);
    v0 = vcount;
    chips(15);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("bad0_novalid", vcount, v0);
    do_load(40);
    chk("bad40_active", bus.active, 0);
    chk("bad40_chip", bus.ca_chip, 0);
    chips(5);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("bad40_novalid", vcount, v0);
    do_load(5);
    chk("prn5_active", bus.active, 1);
    chk("prn5_epoch", bus.epoch, 1);
    chips(12);

    do_load(int'($urandom_range(1, 32)));
    chips(500);
    chk("coin_pre_cnt", bus.chip_cnt, 500);
    step(1'b0, 1'b0, 0, 1'b0);
    p = int'($urandom_range(1, 32));
    step(1'b1, 1'b1, p, 1'b0);
    chk("coin_state", {bus.chip_cnt, bus.ca_chip,
                       bus.epoch, bus.chip_valid}, 13'b0_1_1_0);
    chips(200);
    chips(500);
    chk("rst_pre_cnt", bus.chip_cnt, 700);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 9, 1'b1);
    chk("rst_outs", {bus.ca_chip, bus.chip_valid, bus.epoch,
                     bus.chip_cnt, bus.active}, 0);
    v0 = vcount;
    chips(20);
    chk("rst_idle_active", bus.active, 0);
    chk("rst_idle_novalid", vcount, v0);

    do_load(7);
    acc = 32'd0;
    for (int c = 0; c < 45000 && epochs.size() < 3; c++) begin
      acc += 32'd219687577;
      step(acc[31], 1'b0, 0, 1'b0);
    end
    chk("nco_epochs", epochs.size(), 3);
    chk("nco_period1", epochs[1] - epochs[0], 1023);
    chk("nco_period2", epochs[2] - epochs[1], 1023);
    mism = 0;
    for (int k = 0; k < 1023; k++)
      if (seen[k] != seen[1023+k]) mism++;
    chk("nco_repeat", mism, 0);

    repeat (4) step(1'b0, 1'b0, 0, 1'b0);
    chk("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
